// File: rtl/instr_memory_if.sv
// Fetch and program-load bus between the CPU/boot host and instr_memory.
// master = CPU fetch port plus loader; slave = the instruction memory.
interface instr_memory_if;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        loaded;
    logic [6:0]  load_count;
    logic [15:0] fetch_count;
    logic        halted;
    logic        addr_fault;

    modport master (
        output instr_address, load_valid, load_data, load_last,
        input  instr_readdata, load_ready, loaded, load_count,
               fetch_count, halted, addr_fault
    );

    modport slave (
        input  instr_address, load_valid, load_data, load_last,
        output instr_readdata, load_ready, loaded, load_count,
               fetch_count, halted, addr_fault
    );
endinterface

// File: rtl/instr_memory.sv
// Instruction memory for mips_cpu_harvard: streamed program load, then
// zero-wait-state fetch serving with halt detection and illegal-fetch flagging.
module instr_memory #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR   = 32'h00000000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_enable,
    instr_memory_if.slave  bus
);
    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {LOAD, SERVE, HALT} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [6:0]  load_count;
    logic [15:0] fetch_count;
    logic        loaded;
    logic        load_ready;
    logic        halted;
    logic        addr_fault;

    logic [31:0] offset;
    logic        aligned;
    logic        in_range;
    logic        below_count;
    logic        hit;
    logic        is_halt;
    logic        fault_now;
    logic        accept;
    logic [31:0] rdata;

    // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
    always_comb begin
        offset      = bus.instr_address - BASE_ADDR;
        aligned     = (bus.instr_address[1:0] == 2'b00);
        in_range    = (offset < SPAN);
        below_count = ({2'b00, offset[31:2]} < {25'b0, load_count});
        hit         = aligned && in_range && below_count;
        is_halt     = (bus.instr_address == HALT_ADDR);
        fault_now   = !is_halt && (!aligned || !in_range);
        accept      = (state == LOAD) && bus.load_valid && load_ready;
        rdata       = '0;
        if (state == SERVE && hit)
            rdata = mem[offset[AW+1:2]];
    end

    // Storage has no reset; words past load_count are masked on read instead.
    always_ff @(posedge clk) begin
        if (clk_enable && !reset && accept)
            mem[load_count[AW-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (clk_enable) begin
            if (reset) begin
                state       <= LOAD;
                load_count  <= '0;
                fetch_count <= '0;
                loaded      <= 1'b0;
                load_ready  <= 1'b1;
                halted      <= 1'b0;
                addr_fault  <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (accept) begin
                            load_count <= load_count + 7'd1;
                            if (bus.load_last || load_count == 7'(DEPTH_WORDS - 1)) begin
                                state      <= SERVE;
                                loaded     <= 1'b1;
                                load_ready <= 1'b0;
                            end
                        end
                    end
                    SERVE: begin
                        if (fetch_count != '1)
                            fetch_count <= fetch_count + 16'd1;
                        if (fault_now)
                            addr_fault <= 1'b1;
                        if (is_halt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    end
                    HALT: ;
                    default: state <= LOAD;
                endcase
            end
        end
    end

    assign bus.instr_readdata = rdata;
    assign bus.load_ready     = load_ready;
    assign bus.loaded         = loaded;
    assign bus.load_count     = load_count;
    assign bus.fetch_count    = fetch_count;
    assign bus.halted         = halted;
    assign bus.addr_fault     = addr_fault;
endmodule

// File: tb/tb_instr_memory.sv
// Directed bench for instr_memory: a behavioural model checked every cycle
// plus hand-computed literal expectations at the key points.
module tb_instr_memory;
    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    instr_memory_if bus ();

    instr_memory #(
        .DEPTH_WORDS(64),
        .BASE_ADDR(32'hBFC00000),
        .HALT_ADDR(32'h00000000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_enable(clk_enable),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    // Model: program words, words held, and three phase flags.
    logic [31:0] m_mem [64];
    int          m_count  = 0;
    int          m_fetch  = 0;
    bit          m_loaded = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_fault  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!m_loaded || m_halted) return '0;
        if (off[1:0] != 2'b00 || off >= 32'(4 * m_count)) return '0;
        return m_mem[off[7:2]];
    endfunction

    always @(posedge clk) begin
        if (clk_enable) begin
            if (reset) begin
                m_count = 0; m_fetch = 0;
                m_loaded = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
            end else if (!m_loaded) begin
                if (bus.load_valid) begin
                    m_mem[m_count] = bus.load_data;
                    m_count++;
                    if (bus.load_last || m_count == 64) m_loaded = 1'b1;
                end
            end else if (!m_halted) begin
                if (m_fetch < 65535) m_fetch++;
                if (bus.instr_address != 32'h0 &&
                    (bus.instr_address[1:0] != 2'b00 || (bus.instr_address - BASE) >= 32'd256))
                    m_fault = 1'b1;
                if (bus.instr_address == 32'h0) m_halted = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("readdata",    bus.instr_readdata, exp_rdata(bus.instr_address));
            chk("load_ready",  32'(bus.load_ready), 32'(!m_loaded));
            chk("loaded",      32'(bus.loaded), 32'(m_loaded));
            chk("load_count",  32'(bus.load_count), 32'(m_count));
            chk("fetch_count", 32'(bus.fetch_count), 32'(m_fetch));
            chk("halted",      32'(bus.halted), 32'(m_halted));
            chk("addr_fault",  32'(bus.addr_fault), 32'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_words(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hC0DE0000 + 32'(i);
            bus.load_last  = use_last && (i == n - 1);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clk_enable = 1'b1;
        bus.instr_address = BASE;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        tick();
        checking = 1'b1;
        chk("reset_load_ready", 32'(bus.load_ready), 32'd1);
        chk("reset_load_count", 32'(bus.load_count), 32'd0);
        reset = 1'b0;

        // 16-word program terminated by load_last
        load_words(16, 1'b1);
        chk("t1_loaded", 32'(bus.loaded), 32'd1);
        chk("t1_count", 32'(bus.load_count), 32'd16);
        bus.instr_address = 32'hBFC00008;
        #1;
        chk("t1_word2", bus.instr_readdata, 32'hC0DE0002);
        bus.instr_address = 32'hBFC0003C;
        tick();
        chk("t1_word15", bus.instr_readdata, 32'hC0DE000F);

        // full 64 words, no load_last, extra beat ignored
        do_reset();
        bus.instr_address = BASE;
        load_words(64, 1'b0);
        chk("t2_ready", 32'(bus.load_ready), 32'd0);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hDEADBEEF;
        tick();
        bus.load_valid = 1'b0;
        chk("t2_count", 32'(bus.load_count), 32'd64);
        bus.instr_address = 32'hBFC000FC;
        #1;
        chk("t2_word63", bus.instr_readdata, 32'hC0DE003F);

        // clk_enable low freezes loading; reset mid-load discards
        do_reset();
        load_words(2, 1'b0);
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = ~bus.load_valid;
            tick();
        end
        clk_enable = 1'b1;
        bus.load_valid = 1'b0;
        chk("t5_frozen", 32'(bus.load_count), 32'd2);
        load_words(1, 1'b0);
        chk("t5_three", 32'(bus.load_count), 32'd3);
        do_reset();
        chk("t5_reset_count", 32'(bus.load_count), 32'd0);
        chk("t5_reset_loaded", 32'(bus.loaded), 32'd0);

        // 4-word program: beyond-count miss, then unaligned fault
        bus.instr_address = BASE;
        load_words(4, 1'b1);
        bus.instr_address = 32'hBFC00010;
        #1;
        chk("t3_miss_data", bus.instr_readdata, 32'h0);
        tick();
        chk("t3_no_fault", 32'(bus.addr_fault), 32'd0);
        bus.instr_address = 32'hBFC00002;
        tick();
        chk("t3_fault", 32'(bus.addr_fault), 32'd1);
        bus.instr_address = 32'hBFC00004;
        tick();
        chk("t3_sticky", 32'(bus.addr_fault), 32'd1);
        chk("t3_hit", bus.instr_readdata, 32'hC0DE0001);

        // fetch stream with a branch, ending in a jump to 0
        do_reset();
        bus.instr_address = BASE;
        load_words(8, 1'b1);
        begin
            logic [31:0] trace [6];
            trace = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008,
                      32'hBFC00014, 32'hBFC00018, 32'h00000000};
            for (int i = 0; i < 6; i++) begin
                bus.instr_address = trace[i];
                tick();
            end
        end
        chk("t4_halted", 32'(bus.halted), 32'd1);
        chk("t4_fetch", 32'(bus.fetch_count), 32'd6);
        bus.instr_address = BASE;
        tick(); tick(); tick();
        chk("t4_frozen", 32'(bus.fetch_count), 32'd6);
        chk("t4_no_fault", 32'(bus.addr_fault), 32'd0);
        chk("t4_data0", bus.instr_readdata, 32'h0);

        // below-BASE address faults through wrap
        do_reset();
        load_words(1, 1'b1);
        bus.instr_address = 32'hBFBFFFFC;
        tick();
        chk("wrap_fault", 32'(bus.addr_fault), 32'd1);

        // fetch_count saturation
        do_reset();
        load_words(1, 1'b1);
        bus.instr_address = BASE;
        repeat (70000) tick();
        chk("t6_sat", 32'(bus.fetch_count), 32'h0000FFFF);
        chk("t6_data", bus.instr_readdata, 32'hC0DE0000);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
